// File: rtl/dft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dft_pkg
// Brief    : Default sizing constants for the multi-octave DFT datapath.
// Revision : 1.0 - initial release
// ============================================================================
package dft_pkg;
    localparam int c_OCT  = 5;
    localparam int c_BINS = 24;
    localparam int c_N    = 16;
endpackage
`default_nettype wire

// File: rtl/octave_storage.sv
`default_nettype none
// ============================================================================
// Module   : octave_storage
// Brief    : Delayed-write shift register holding the most recent samples.
// Revision : 1.0 - initial release
// ============================================================================
module octave_storage #(
    parameter int N    = 16,
    parameter int SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N-1:0] newSample,
    input  logic                writeSample,
    output logic signed [N-1:0] sample0,
    output logic signed [N-1:0] sample1,
    output logic signed [N-1:0] oldestSample
);
    logic                r_pend_valid;
    logic signed [N-1:0] r_pend_data;
    logic signed [N-1:0] r_entries [SIZE];

    // A write request lands in the store one edge after it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
        end else begin
            r_pend_valid <= writeSample;
            r_pend_data  <= newSample;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entries[0] <= '0;
        end else if (r_pend_valid) begin
            r_entries[0] <= r_pend_data;
        end
    end

    for (genvar i = 1; i < SIZE; i++) begin : g_shift
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_entries[i] <= '0;
            end else if (r_pend_valid) begin
                r_entries[i] <= r_entries[i-1];
            end
        end
    end

    assign sample0      = r_entries[0];
    assign sample1      = r_entries[1];
    assign oldestSample = r_entries[SIZE-1];
endmodule
`default_nettype wire

// File: rtl/dft_octave_support.sv
`default_nettype none
// ============================================================================
// Module   : dft_octave_support
// Brief    : Operation sequencer, octave write-pulse select and sample store.
// Revision : 1.0 - initial release
// ============================================================================
module dft_octave_support
    import dft_pkg::*;
#(
    parameter int OCT   = c_OCT,
    parameter int BINS  = c_BINS,
    parameter int LINES = 4,
    parameter int N     = c_N,
    parameter int SIZE  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    enable,
    output logic [((OCT > 1) ? $clog2(OCT) : 1)-1:0]   octave,
    output logic                                    operation,
    output logic [((BINS > 1) ? $clog2(BINS) : 1)-1:0] bin,
    output logic                                    finished,
    input  logic                                    incr,
    output logic [LINES-1:0]                        writeLines,
    input  logic signed [N-1:0]                     newSample,
    input  logic                                    writeSample,
    output logic signed [N-1:0]                     sample0,
    output logic signed [N-1:0]                     sample1,
    output logic signed [N-1:0]                     oldestSample
);
    localparam int c_OCT_W = (OCT > 1) ? $clog2(OCT) : 1;
    localparam int c_BIN_W = (BINS > 1) ? $clog2(BINS) : 1;
    localparam logic [c_OCT_W-1:0] c_OCT_LAST = c_OCT_W'(OCT - 1);
    localparam logic [c_BIN_W-1:0] c_BIN_LAST = c_BIN_W'(BINS - 1);

    logic [c_OCT_W-1:0] r_octave;
    logic               r_operation;
    logic [c_BIN_W-1:0] r_bin;
    logic               r_started;
    logic [LINES-1:0]   r_count;

    // The first enabled edge only arms the counter, so bin 0 is held for a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_octave    <= '0;
            r_operation <= 1'b0;
            r_bin       <= '0;
            r_started   <= 1'b0;
        end else if (!enable) begin
            r_octave    <= '0;
            r_operation <= 1'b0;
            r_bin       <= '0;
            r_started   <= 1'b0;
        end else if (!r_started) begin
            r_started <= 1'b1;
        end else if (r_bin == c_BIN_LAST) begin
            r_bin       <= '0;
            r_operation <= ~r_operation;
            if (r_operation) begin
                r_octave <= (r_octave == c_OCT_LAST) ? '0 : r_octave + 1'b1;
            end
        end else begin
            r_bin <= r_bin + 1'b1;
        end
    end

    assign octave    = r_octave;
    assign operation = r_operation;
    assign bin       = r_bin;
    assign finished  = (r_bin == c_BIN_LAST) && r_operation && (r_octave == c_OCT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (incr) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Lowest set bit: line k fires every 2^(k+1) increments.
    assign writeLines = r_count & (~r_count + 1'b1);

    octave_storage #(
        .N    (N),
        .SIZE (SIZE)
    ) u_storage (
        .clk          (clk),
        .rst          (rst),
        .newSample    (newSample),
        .writeSample  (writeSample),
        .sample0      (sample0),
        .sample1      (sample1),
        .oldestSample (oldestSample)
    );
endmodule
`default_nettype wire

// File: tb/tb_dft_octave_support.sv
`default_nettype none
// ============================================================================
// Module   : tb_dft_octave_support
// Brief    : Scoreboard bench for dft_octave_support.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dft_octave_support;
    logic               clk;
    logic               rst;
    logic               enable;
    logic [2:0]         octave;
    logic               operation;
    logic [4:0]         bin;
    logic               finished;
    logic               incr;
    logic [3:0]         writeLines;
    logic signed [15:0] newSample;
    logic               writeSample;
    logic signed [15:0] sample0;
    logic signed [15:0] sample1;
    logic signed [15:0] oldestSample;

    dft_octave_support #(
        .OCT(5), .BINS(24), .LINES(4), .N(16), .SIZE(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .octave       (octave),
        .operation    (operation),
        .bin          (bin),
        .finished     (finished),
        .incr         (incr),
        .writeLines   (writeLines),
        .newSample    (newSample),
        .writeSample  (writeSample),
        .sample0      (sample0),
        .sample1      (sample1),
        .oldestSample (oldestSample)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]         kind;   // 0 all, 1 counter, 2 lines, 3 storage
        logic [2:0]         oct;
        logic               op;
        logic [4:0]         bin;
        logic               fin;
        logic [3:0]         lines;
        logic signed [15:0] s0;
        logic signed [15:0] s1;
        logic signed [15:0] so;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push_cnt(input int o, input int p, input int b);
        exp_t e;
        e = '0;
        e.kind = 2'd1;
        e.oct  = 3'(o);
        e.op   = 1'(p);
        e.bin  = 5'(b);
        e.fin  = (o == 4) && (p == 1) && (b == 23);
        q.push_back(e);
    endtask

    task automatic push_lines(input logic [3:0] l);
        exp_t e;
        e = '0;
        e.kind  = 2'd2;
        e.lines = l;
        q.push_back(e);
    endtask

    task automatic push_store(input int a, input int b, input int c);
        exp_t e;
        e = '0;
        e.kind = 2'd3;
        e.s0   = 16'(a);
        e.s1   = 16'(b);
        e.so   = 16'(c);
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every falling edge with a queued expectation is one comparison.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic ok;
            e = q.pop_front();
            n_cmp++;
            ok = 1'b1;
            case (e.kind)
                2'd1: ok = (octave == e.oct) && (operation == e.op) && (bin == e.bin)
                           && (finished == e.fin);
                2'd2: ok = (writeLines == e.lines);
                2'd3: ok = (sample0 == e.s0) && (sample1 == e.s1) && (oldestSample == e.so);
                default: ok = (octave == 3'd0) && !operation && (bin == 5'd0) && !finished
                              && (writeLines == 4'd0) && (sample0 == 16'sd0)
                              && (sample1 == 16'sd0) && (oldestSample == 16'sd0);
            endcase
            if (!ok) begin
                n_bad++;
                case (e.kind)
                    2'd1: $display("FAIL counter: got oct=%0d op=%0d bin=%0d fin=%0d, want oct=%0d op=%0d bin=%0d fin=%0d",
                                   octave, operation, bin, finished, e.oct, e.op, e.bin, e.fin);
                    2'd2: $display("FAIL writeLines: got %b, want %b", writeLines, e.lines);
                    2'd3: $display("FAIL storage: got %0d/%0d/%0d, want %0d/%0d/%0d",
                                   sample0, sample1, oldestSample, e.s0, e.s1, e.so);
                    default: $display("FAIL reset: got oct=%0d op=%0d bin=%0d fin=%0d lines=%b s=%0d/%0d/%0d, want all zero",
                                      octave, operation, bin, finished, writeLines,
                                      sample0, sample1, oldestSample);
                endcase
            end
        end
    end

    initial begin
        int idx;
        int wr_vals [9];
        int wr_exp  [9][3];
        logic [3:0] pulses [9];

        rst = 1'b1; enable = 1'b0; incr = 1'b0; writeSample = 1'b0; newSample = '0;
        step();
        step();
        q.push_back('0);
        step();
        rst = 1'b0;
        enable = 1'b1;

        // Start-up edge holds bin 0, then one step per edge through all octaves.
        idx = 0;
        for (int o = 0; o < 5; o++) begin
            for (int p = 0; p < 2; p++) begin
                for (int b = 0; b < 24; b++) begin
                    step();
                    push_cnt(o, p, b);
                    idx++;
                end
            end
        end

        enable = 1'b0;
        for (int k = 0; k < 5; k++) step();
        push_cnt(0, 0, 0);

        // Write-pulse generator.
        step();
        push_lines(4'b0000);
        step();
        push_lines(4'b0000);
        incr = 1'b1;
        pulses = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001,
                   4'b0010, 4'b0001, 4'b1000, 4'b0001};
        for (int k = 0; k < 9; k++) begin
            step();
            push_lines(pulses[k]);
        end
        incr = 1'b0;

        // Storage: the first write only reaches the pending stage.
        wr_vals = '{100, 222, -333, 444, 555, 666, 777, 888, 9999};
        wr_exp  = '{'{0, 0, 0}, '{100, 0, 0}, '{222, 100, 0}, '{-333, 222, 0},
                    '{444, -333, 0}, '{555, 444, 0}, '{666, 555, 0}, '{777, 666, 0},
                    '{888, 777, 100}};
        writeSample = 1'b1;
        for (int k = 0; k < 9; k++) begin
            newSample = 16'(wr_vals[k]);
            step();
            push_store(wr_exp[k][0], wr_exp[k][1], wr_exp[k][2]);
        end
        newSample = 16'sd0;
        step();
        push_store(9999, 888, 222);
        writeSample = 1'b0;
        newSample = -16'sd1;
        step();
        push_store(0, 9999, -333);
        step();
        push_store(0, 9999, -333);
        step();
        push_store(0, 9999, -333);

        for (int k = 0; k < 20 && q.size() > 0; k++) step();
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dft_octave_support.md
Name: dft_octave_support

Overview:
- Control and storage support block for the multi-octave DFT datapath.
- Three independent functions share one clock and reset:
  - an operation counter that sequences octave/operation/bin;
  - a write-pulse generator that selects which octave line receives the next decimated sample;
  - an octave sample store, a delayed-write shift register exposing the two newest and the oldest samples.

Parameters:
- OCT, 5, number of octaves sequenced by the counter.
- BINS, 24, bins per operation pass.
- LINES, 4, width of writeLines (octave write lines).
- N, 16, signed sample width.
- SIZE, 8, sample store depth (entries 0..SIZE-1); SIZE >= 3.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  operation counter run; low clears the counter.
- octave  out  $clog2(OCT)  current octave.
- operation  out  1  current operation (0 first pass, 1 second pass).
- bin  out  $clog2(BINS)  current bin.
- finished  out  1  last step of the whole sequence.
- incr  in  1  advance the write-pulse counter.
- writeLines  out  LINES  one-hot (or zero) write select.
- newSample  in  N signed  sample to store.
- writeSample  in  1  write request for newSample.
- sample0  out  N signed  newest stored sample (entry 0).
- sample1  out  N signed  entry 1.
- oldestSample  out  N signed  entry SIZE-1.

Behaviour:
- Clock and reset: one clock; reset asynchronous and active-high, all state cleared to zero.

Operation counter:
- Internal started flag.
- On a clock edge with enable=0: bin, operation, octave and started all clear to 0.
- On an edge with enable=1 and started=0: started<=1, counters hold. This gives one start-up cycle at bin 0.
- On an edge with enable=1 and started=1, advance the counters:
  - bin increments each edge;
  - at bin==BINS-1, bin wraps to 0 and operation toggles;
  - when operation==1 and bin wraps, octave increments;
  - at octave==OCT-1, octave wraps to 0.
- finished is combinational: bin==BINS-1 && operation==1 && octave==OCT-1.
- Order: oct0/op0/bins 0..BINS-1, oct0/op1, oct1/op0 … oct(OCT-1)/op1.
- After finished, an enabled edge wraps everything to 0 and the sequence restarts.

Write-pulse generator:
- LINES-bit counter, cleared by reset; increments on each edge with incr=1 and wraps modulo 2^LINES.
- writeLines is combinational: the lowest set bit of the counter (count & -count); all zero when count==0.
- writeLines is not gated by incr.

Octave storage:
- Registered write stage: each edge, pendValid<=writeSample and pendData<=newSample.
- On an edge with pendValid=1, the store shifts: entry0<=pendData, entry[i]<=entry[i-1].
- Visible latency: a sample written at edge k appears on sample0 after edge k+1, even if writeSample=0 at edge k+1.
- With no pending write, entries hold.
- Reset clears entries and the pending stage.
- Outputs are direct register reads of entries 0, 1 and SIZE-1.

Decomposition:
- Shared package (dft_pkg): default OCT, BINS, N constants.
- Sub-module octave_storage: the pending-write stage plus the SIZE-deep shift register, parameterised by N and SIZE.
- Counter and pulse generator stay inline in the top.

Test Plan:
- Operation counter sequence: reset with enable=1, one edge -> bin 0, op 0, oct 0, finished 0. Then per edge, bin 0..23 op0, bin 0..23 op1, for oct 0..4. finished=1 only at oct4/op1/bin23.
- Operation counter clear: at finished, drop enable and run 5 edges -> bin 0, operation 0, octave 0, finished 0.
- Write-pulse sequence: reset, incr=0 for 2 edges -> writeLines 0000. Then incr=1, per edge -> 0001, 0010, 0001, 0100, 0001, 0010, 0001, 1000, 0001.
- Storage latency (N=16, SIZE=8): write 100 then 222 on consecutive edges -> sample0 100, sample1 0, old 0. Write -333 -> 222/100/0. Write 444 -> -333/222/0.
- Storage fill: continue writing 555, 666, 777, 888, 9999 -> 888/777/100. Write 0 -> 9999/888/222.
- Storage pending drain: writeSample=0, newSample=-1, one edge -> 0/9999/-333. A further edge -> unchanged (-1 never stored).
